// File: rtl/muldiv_sequencer.sv
// HI/LO owner for the EX stage: single-cycle multiply, 32-step restoring divide,
// and the stall that holds consumers back while a divide is still running.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             readReq_i,
   input  logic             readHi_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] readData_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             divByZero_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIV_RUN = 2'd1,
      DIV_FIX = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             divByZero_q, divByZero_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dividend_q, dividend_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic             quotSign_q, quotSign_d;
   logic             remSign_q, remSign_d;

   logic             signedOp;
   logic [2*WIDTH-1:0] aExt, bExt, product;
   logic [WIDTH-1:0] absA, absB;
   logic [WIDTH:0]   remShift, remDiff;
   logic             quotBit;

   assign signedOp = ~op_i[0];

   // Both operands are extended to the full product width so one multiplier
   // covers mult and multu; the low 2*WIDTH bits are exact either way.
   always_comb begin
      aExt = signedOp ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
      bExt = signedOp ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
      product = aExt * bExt;
      absA = (signedOp && a_i[WIDTH-1]) ? -a_i : a_i;
      absB = (signedOp && b_i[WIDTH-1]) ? -b_i : b_i;
   end

   // One restoring step: the remainder needs one extra bit before the compare.
   always_comb begin
      remShift = {rem_q, dividend_q[WIDTH-1]};
      remDiff  = remShift - {1'b0, divisor_q};
      quotBit  = (remShift >= {1'b0, divisor_q});
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      rem_d       = rem_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      quotSign_d  = quotSign_q;
      remSign_d   = remSign_q;
      divByZero_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (!op_i[1]) begin
                  {hi_d, lo_d} = product;
               end else if (b_i == '0) begin
                  hi_d        = a_i;
                  lo_d        = '1;
                  divByZero_d = 1'b1;
               end else begin
                  dividend_d = absA;
                  divisor_d  = absB;
                  quotSign_d = signedOp & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  remSign_d  = signedOp & a_i[WIDTH-1];
                  rem_d      = '0;
                  count_d    = CW'(WIDTH - 1);
                  state_d    = DIV_RUN;
               end
            end
         end

         DIV_RUN: begin
            rem_d      = quotBit ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
            dividend_d = {dividend_q[WIDTH-2:0], quotBit};
            if (count_q == '0) begin
               state_d = DIV_FIX;
            end else begin
               count_d = count_q - 1'b1;
            end
         end

         DIV_FIX: begin
            lo_d    = quotSign_q ? -dividend_q : dividend_q;
            hi_d    = remSign_q ? -rem_q : rem_q;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         divByZero_q <= 1'b0;
         count_q     <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         rem_q       <= '0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         quotSign_q  <= 1'b0;
         remSign_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         divByZero_q <= divByZero_d;
         count_q     <= count_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         rem_q       <= rem_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         quotSign_q  <= quotSign_d;
         remSign_q   <= remSign_d;
      end
   end

   assign stall_o     = busy_q & (start_i | readReq_i);
   assign busy_o      = busy_q;
   assign readData_o  = readHi_i ? hi_q : lo_q;
   assign hi_o        = hi_q;
   assign lo_o        = lo_q;
   assign divByZero_o = divByZero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and random checks of muldiv_sequencer against an arithmetic model
// of HI/LO results, divide latency, stall behaviour and reset.
module tb_muldiv_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         readReq, readHi;
   logic         stall, busy, divByZero;
   logic [W-1:0] readData, hi, lo;

   int checks = 0;
   int errors = 0;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .readReq_i(readReq), .readHi_i(readHi), .stall_o(stall), .busy_o(busy),
      .readData_o(readData), .hi_o(hi), .lo_o(lo), .divByZero_o(divByZero)
   );

   always #5 clk = ~clk;

   // Expected {HI, LO} straight from the instruction semantics.
   function automatic logic [63:0] refModel(input logic [1:0] mop, input logic [31:0] ma,
                                            input logic [31:0] mb);
      longint sa, sb, sq, sr;
      logic [63:0] up;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      case (mop)
         2'b00: begin
            sq = sa * sb;
            return 64'(sq);
         end
         2'b01: begin
            up = 64'(ma) * 64'(mb);
            return up;
         end
         default: begin
            if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
            if (mop == 2'b11) return {ma % mb, ma / mb};
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
         end
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [31:0] va,
                                input logic [31:0] vb, input logic rr, input logic rh);
      start = s; op = o; a = va; b = vb; readReq = rr; readHi = rh;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts busy/stall cycles until the divider drains, giving up after a bound.
   task automatic waitDivDone(output int busyCnt, output int stallCnt);
      busyCnt = 0;
      stallCnt = 0;
      while (busy && busyCnt < 40) begin
         busyCnt++;
         if (stall) stallCnt++;
         tick();
      end
   endtask

   // Issue one op, follow it with an mfhi, and check everything the model predicts.
   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] va,
                        input logic [31:0] vb);
      logic [63:0] exp;
      int bc, sc;
      exp = refModel(o, va, vb);
      applyStimulus(1'b1, o, va, vb, 1'b0, 1'b0);
      checkOutput({tag, " acceptStall"}, 64'(stall), 64'd0);
      tick();
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1);
      if (o[1] && vb != 32'd0) begin
         waitDivDone(bc, sc);
         checkOutput({tag, " busyCycles"}, 64'(bc), 64'd33);
         checkOutput({tag, " stallCycles"}, 64'(sc), 64'd33);
      end else begin
         checkOutput({tag, " busy"}, 64'(busy), 64'd0);
         checkOutput({tag, " dbzPulse"}, 64'(divByZero), 64'(o[1]));
      end
      checkOutput({tag, " readHi"}, 64'(readData), 64'(exp[63:32]));
      checkOutput({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
      checkOutput({tag, " stallAfter"}, 64'(stall), 64'd0);
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      checkOutput({tag, " dbzLow"}, 64'(divByZero), 64'd0);
   endtask

   initial begin
      int bc, sc;
      logic [1:0] rop;
      logic [31:0] ra, rb;

      $display("[TB] muldiv_sequencer bench start");
      rst = 1'b1;
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset hi", 64'(hi), 64'd0);
      checkOutput("reset lo", 64'(lo), 64'd0);
      checkOutput("reset dbz", 64'(divByZero), 64'd0);
      checkOutput("reset stall", 64'(stall), 64'd0);
      checkOutput("reset readLo", 64'(readData), 64'd0);

      runOp("mult -1*1", 2'b00, 32'hFFFF_FFFF, 32'd1);
      runOp("divu 11/3", 2'b11, 32'd11, 32'd3);
      runOp("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
      runOp("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      runOp("div 5/0", 2'b10, 32'd5, 32'd0);
      runOp("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Read and new op in the same IDLE cycle: the read sees the old LO.
      applyStimulus(1'b1, 2'b00, 32'd3, 32'd4, 1'b1, 1'b0);
      checkOutput("rdStart oldLo", 64'(readData), 64'(refModel(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF) & 64'hFFFF_FFFF));
      tick();
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("rdStart newLo", 64'(lo), 64'd12);

      // Reset in the middle of a divide discards it.
      applyStimulus(1'b1, 2'b11, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("midReset busyBefore", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1);
      checkOutput("midReset busy", 64'(busy), 64'd0);
      checkOutput("midReset stall", 64'(stall), 64'd0);
      checkOutput("midReset readHi", 64'(readData), 64'd0);
      tick();
      checkOutput("midReset stays idle", 64'(busy), 64'd0);

      // Second divide held by stall, accepted the cycle busy falls.
      applyStimulus(1'b1, 2'b10, 32'd6, 32'd3, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 2'b10, 32'd10, 32'd3, 1'b0, 1'b0);
      waitDivDone(bc, sc);
      checkOutput("b2b first busy", 64'(bc), 64'd33);
      checkOutput("b2b first stall", 64'(sc), 64'd33);
      checkOutput("b2b first hi", 64'(hi), 64'd0);
      checkOutput("b2b first lo", 64'(lo), 64'd2);
      checkOutput("b2b release", 64'(stall), 64'd0);
      tick();
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1);
      waitDivDone(bc, sc);
      checkOutput("b2b second busy", 64'(bc), 64'd33);
      checkOutput("b2b second hi", 64'(readData), 64'd1);
      checkOutput("b2b second lo", 64'(lo), 64'd3);
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();

      for (int n = 0; n < 24; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 20));
            2: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         runOp($sformatf("rand%0d op%0d", n, rop), rop, ra, rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide sequencer for the EX stage: owns the HI/LO register pair and sequences a 32-iteration restoring divider next to the single-cycle ALU path. It accepts mult/multu/div/divu issued from ID/EX and serves mfhi/mflo reads. It also raises a stall to the hazard logic whenever a consumer or a new mul/div op arrives while a divide is still running.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width (iteration count = WIDTH)

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- Start  in  1  mul/div op valid in EX this cycle
- Op  in  2  00 mult, 01 multu, 10 div, 11 divu
- A  in  WIDTH  rs operand (post-forwarding)
- B  in  WIDTH  rt operand (post-forwarding)
- ReadReq  in  1  mfhi/mflo in EX this cycle
- ReadHi  in  1  1 = mfhi, 0 = mflo
- Stall  out  1  freeze PC/IF/ID/ID-EX this cycle (combinational)
- Busy  out  1  divide in progress (registered)
- ReadData  out  WIDTH  ReadHi ? Hi : Lo (combinational)
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register
- DivByZero  out  1  one-cycle pulse, registered

## Operation
- States: IDLE, DIV_RUN, DIV_FIX.
- Stall = Busy & (Start | ReadReq). An op is accepted only when Start=1 and Stall=0, i.e. in IDLE.
- Mult/multu accepted: {Hi,Lo} <= 64-bit product (signed for mult, unsigned for multu) at the accepting edge. State stays IDLE.
- Div/divu accepted with B != 0:
  - Latch |A| and |B| (raw values for divu) and the result signs: quotient sign = A[31]^B[31], remainder sign = A[31]; signed only.
  - Clear the partial remainder, set the counter to WIDTH-1, go DIV_RUN.
- DIV_RUN, per cycle, one restoring step: rem = {rem, dividend MSB}; if rem >= divisor then rem -= divisor and the quotient bit is 1. Decrement the counter; after the step with counter 0, go DIV_FIX.
- DIV_FIX: apply the latched signs (two's-complement negate), write Lo = quotient, Hi = remainder, go IDLE.
- Div/divu accepted with B == 0: no iteration. Hi <= A, Lo <= all-ones, DivByZero pulses high the next cycle. State stays IDLE.
- Signed overflow (0x80000000 / -1) follows naturally: Lo = 0x80000000, Hi = 0.
- Hi/Lo never change in DIV_RUN. ReadData during Busy is stale, but Stall is asserted, so it is never consumed.
- A Start that arrives while Busy is held by Stall and accepted in the first IDLE cycle.

## Timing
- Reset (any state, including mid-divide): state IDLE, Busy=0, Hi=0, Lo=0, DivByZero=0, counter=0, divider datapath cleared. The in-flight divide is discarded.
- Mult latency: result visible on Hi/Lo 1 cycle after the accepting edge. An mfhi in the next cycle reads it with no stall.
- Div latency:
  - Accept at edge E0.
  - Busy=1 after E0 through E33: 32 DIV_RUN cycles plus 1 DIV_FIX cycle.
  - Hi/Lo written at E33.
  - Busy=0 and the result readable in the cycle after E33.
- Stall is high in every cycle between E0 and E33 in which ReadReq or Start is high. It drops in the same cycle Hi/Lo show the result.
- Simultaneous ReadReq and Start while IDLE: the read returns the old Hi/Lo, then the new op is accepted at that edge.
- Start held high across IDLE cycles: each cycle with Stall=0 is a new accepted op. The pipeline is responsible for deasserting Start.

## Test plan
- Reset, then mult A=0xFFFFFFFF (-1), B=1 -> next cycle Hi=0xFFFFFFFF, Lo=0xFFFFFFFF, Busy never rises.
- divu A=11, B=3, then mfhi issued the following cycle -> Stall=1 for 33 cycles, Busy high 33 cycles, then ReadData=2 (Hi) and Lo=3.
- div A=-7 (0xFFFFFFF9), B=2 -> after completion Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). Also div 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- div A=5, B=0 -> Busy stays 0, DivByZero pulses one cycle, Hi=5, Lo=0xFFFFFFFF.
- divu 0xFFFFFFFF / 2 started, Reset asserted at iteration 10, then mfhi -> Busy=0 and Stall=0 after the reset edge, ReadData=0.
- A second div issued while the first is Busy -> the second is stalled, accepted the cycle Busy falls, and its result (10/3: Hi=1, Lo=3) lands 33 cycles later. The first result (6/3: Hi=0, Lo=2) is observed in between.
